// File: rtl/brute_force_engine.sv
// -----------------------------------------------------------------------------
// brute_force_engine
//
// Purpose:
//   Generates candidate passwords of increasing length (1..MAX_LEN characters)
//   over the character range CHAR_MIN..CHAR_MAX and compares one candidate per
//   cycle against a registered target. The search stops on a match (FOUND) or
//   when the space is exhausted (EXHAUSTED). Byte 0 of a candidate is
//   interleaved across parallel instances via startingPosition/increment.
//   Higher bytes step by one.
//
// Timing:
//   A start pulse sampled at edge 0 registers target, offset and stride.
//   Edge 1 validates them and loads candidate 1. Candidate k is present after
//   edge k. The compare result of candidate k is registered at edge k+1.
//
// Configuration macro:
//   BRUTE_FORCE_ATTEMPT_COUNT_EN - when defined, the 64-bit attempts counter is
//   built. When undefined, attempts is tied to zero.
//
// Ports:
//   clock            in   single clock, rising edge
//   reset            in   synchronous active-high reset
//   start            in   one-cycle pulse, accepted in IDLE/FOUND/EXHAUSTED
//   abort            in   return to IDLE from any state (wins over start)
//   target           in   8*MAX_LEN target, byte 0 = first character
//   startingPosition in   byte-0 offset from CHAR_MIN
//   increment        in   byte-0 stride, 0 treated as 1
//   busy             out  high while searching
//   done             out  search finished (found or exhausted)
//   found            out  match found, valid with done
//   wordLength       out  length of current/held candidate
//   password         out  current/held candidate, unused bytes zero
//   attempts         out  candidates compared
// -----------------------------------------------------------------------------
module brute_force_engine #(
   parameter int         MAX_LEN  = 16,
   parameter logic [7:0] CHAR_MIN = 8'h61,
   parameter logic [7:0] CHAR_MAX = 8'h7A
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [8*MAX_LEN-1:0] target,
   input  logic [2:0]           startingPosition,
   input  logic [2:0]           increment,
   output logic                 busy,
   output logic                 done,
   output logic                 found,
   output logic [7:0]           wordLength,
   output logic [8*MAX_LEN-1:0] password,
   output logic [63:0]          attempts
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEARCH    = 2'd1,
      FOUND     = 2'd2,
      EXHAUSTED = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 pend_q, pend_d;      // start captured, load on next edge
   logic [8*MAX_LEN-1:0] target_q, target_d;
   logic [8*MAX_LEN-1:0] pw_q, pw_d;
   logic [2:0]           offset_q, offset_d;
   logic [2:0]           inc_q, inc_d;
   logic [7:0]           len_q, len_d;

   logic [8*MAX_LEN-1:0] adv_pw;    // candidate after one odometer step
   logic [8*MAX_LEN-1:0] grow_pw;   // odometer rolled over: one byte longer
   logic [8*MAX_LEN-1:0] first_pw;  // first candidate of a search
   logic [MAX_LEN-1:0]   carry;     // carry out of each position
   logic [MAX_LEN-1:0]   last_wrap; // carry out of the top used position
   logic [7:0]           base0;
   logic                 wrap;
   logic                 match;
   logic                 start_bad;

   assign base0 = CHAR_MIN + {5'b0, offset_q};

   // Per-position odometer. Sums are 9 bits wide so that a stride pushing
   // byte 0 past 8'hFF still reads as an overflow.
   genvar gi;
   generate
      for (gi = 0; gi < MAX_LEN; gi++) begin : g_pos
         logic [7:0] cur;
         logic [8:0] sum;
         logic       active;

         assign cur    = pw_q[8*gi +: 8];
         assign active = (len_q > 8'(gi));

         if (gi == 0) begin : g_lsb
            assign sum      = {1'b0, cur} + {6'b0, inc_q};
            assign carry[0] = active & (sum > {1'b0, CHAR_MAX});
            // Byte 0 reloads the instance's own start, not CHAR_MIN.
            assign adv_pw[7:0]   = carry[0] ? base0 : sum[7:0];
            assign first_pw[7:0] = base0;
         end else begin : g_upper
            assign sum       = {1'b0, cur} + 9'd1;
            assign carry[gi] = active & carry[gi-1] & (sum > {1'b0, CHAR_MAX});
            assign adv_pw[8*gi +: 8] = (active & carry[gi-1])
                                      ? (carry[gi] ? CHAR_MIN : sum[7:0])
                                      : cur;
            assign first_pw[8*gi +: 8] = 8'h00;
         end

         assign last_wrap[gi] = carry[gi] & (len_q == 8'(gi + 1));
         // On rollover every used byte already holds its wrapped value; only
         // the newly exposed position needs CHAR_MIN.
         assign grow_pw[8*gi +: 8] = (len_q == 8'(gi)) ? CHAR_MIN : adv_pw[8*gi +: 8];
      end
   endgenerate

   assign wrap  = |last_wrap;
   assign match = (pw_q == target_q);

   assign start_bad = (offset_q >= inc_q) ||
                      (({1'b0, CHAR_MIN} + {6'b0, offset_q}) > {1'b0, CHAR_MAX});

   always_comb begin
      state_d  = state_q;
      pend_d   = 1'b0;
      target_d = target_q;
      offset_d = offset_q;
      inc_d    = inc_q;
      pw_d     = pw_q;
      len_d    = len_q;
      if (abort) begin
         state_d = IDLE;
         pw_d    = '0;
         len_d   = '0;
      end else begin
         case (state_q)
            SEARCH: begin
               if (match) begin
                  state_d = FOUND;
               end else if (wrap) begin
                  if (len_q == 8'(MAX_LEN)) begin
                     state_d = EXHAUSTED;
                  end else begin
                     len_d = len_q + 8'd1;
                     pw_d  = grow_pw;
                  end
               end else begin
                  pw_d = adv_pw;
               end
            end
            default: begin
               if (pend_q) begin
                  if (start_bad) begin
                     state_d = EXHAUSTED;
                     pw_d    = '0;
                     len_d   = '0;
                  end else begin
                     state_d = SEARCH;
                     pw_d    = first_pw;
                     len_d   = 8'd1;
                  end
               end else if (start) begin
                  pend_d   = 1'b1;
                  target_d = target;
                  offset_d = startingPosition;
                  inc_d    = (increment == 3'd0) ? 3'd1 : increment;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         pend_q   <= 1'b0;
         target_q <= '0;
         offset_q <= '0;
         inc_q    <= 3'd1;
         pw_q     <= '0;
         len_q    <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         target_q <= target_d;
         offset_q <= offset_d;
         inc_q    <= inc_d;
         pw_q     <= pw_d;
         len_q    <= len_d;
      end
   end

`ifdef BRUTE_FORCE_ATTEMPT_COUNT_EN
   logic [63:0] attempts_q, attempts_d;

   // Every SEARCH cycle compares exactly one candidate, including the match.
   always_comb begin
      attempts_d = attempts_q;
      if (abort || (pend_q && (state_q != SEARCH))) begin
         attempts_d = '0;
      end else if (state_q == SEARCH) begin
         attempts_d = attempts_q + 64'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         attempts_q <= '0;
      end else begin
         attempts_q <= attempts_d;
      end
   end

   assign attempts = attempts_q;
`else
   assign attempts = 64'd0;
`endif

   assign busy       = (state_q == SEARCH);
   assign done       = (state_q == FOUND) || (state_q == EXHAUSTED);
   assign found      = (state_q == FOUND);
   assign wordLength = len_q;
   assign password   = pw_q;

endmodule

// File: tb/tb_brute_force_engine.sv
// -----------------------------------------------------------------------------
// tb_brute_force_engine
//
// Directed bench for brute_force_engine with MAX_LEN=2 over 'a'..'c'.
// String literals put their last character in byte 0, so "ba" means
// byte1='b', byte0='a'; byte 0 is the fastest-moving position.
// -----------------------------------------------------------------------------
module tb_brute_force_engine;

   localparam int MAX_LEN = 2;

   logic                 clock;
   logic                 reset;
   logic                 start;
   logic                 abort;
   logic [8*MAX_LEN-1:0] target;
   logic [2:0]           startingPosition;
   logic [2:0]           increment;
   logic                 busy;
   logic                 done;
   logic                 found;
   logic [7:0]           wordLength;
   logic [8*MAX_LEN-1:0] password;
   logic [63:0]          attempts;

   int checks_total;
   int checks_passed;

   brute_force_engine #(
      .MAX_LEN  (MAX_LEN),
      .CHAR_MIN (8'h61),
      .CHAR_MAX (8'h63)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .abort            (abort),
      .target           (target),
      .startingPosition (startingPosition),
      .increment        (increment),
      .busy             (busy),
      .done             (done),
      .found            (found),
      .wordLength       (wordLength),
      .password         (password),
      .attempts         (attempts)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
      checks_total++;
      if (obs === exp_val) begin
         checks_passed++;
         $display("ok   %-22s got %0h", tag, obs);
      end else begin
         $display("FAIL %-22s got %0h expected %0h", tag, obs, exp_val);
      end
   endtask

   // Advance n rising edges, then settle on the following falling edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      @(negedge clock);
   endtask

   // Pulse start across edge 0; returns just after edge 0.
   task automatic launch(input logic [15:0] tgt, input logic [2:0] off, input logic [2:0] inc);
      target           = tgt;
      startingPosition = off;
      increment        = inc;
      start            = 1'b1;
      tick(1);
      start            = 1'b0;
   endtask

   function automatic logic [63:0] exp_att(input int n);
`ifdef BRUTE_FORCE_ATTEMPT_COUNT_EN
      return 64'(n);
`else
      return 64'd0;
`endif
   endfunction

   task automatic check_cleared(input string pfx);
      check({pfx, "_busy"},  {63'd0, busy},  64'd0);
      check({pfx, "_done"},  {63'd0, done},  64'd0);
      check({pfx, "_found"}, {63'd0, found}, 64'd0);
      check({pfx, "_len"},   {56'd0, wordLength}, 64'd0);
      check({pfx, "_pw"},    {48'd0, password}, 64'd0);
      check({pfx, "_att"},   attempts, 64'd0);
   endtask

   initial begin
      checks_total     = 0;
      checks_passed    = 0;
      reset            = 1'b1;
      start            = 1'b0;
      abort            = 1'b0;
      target           = '0;
      startingPosition = '0;
      increment        = '0;
      tick(2);
      check_cleared("rst");
      reset = 1'b0;
      tick(1);

      // Target "ba", inc 1: a,b,c,aa,ab,ac,ba
      launch(16'h6261, 3'd0, 3'd1);
      tick(1);                                   // after edge 1
      check("t1_cand1_pw",  {48'd0, password}, 64'h0061);
      check("t1_cand1_len", {56'd0, wordLength}, 64'd1);
      check("t1_cand1_busy", {63'd0, busy}, 64'd1);
      tick(3);                                   // after edge 4
      check("t1_cand4_pw",  {48'd0, password}, 64'h6161);
      check("t1_cand4_len", {56'd0, wordLength}, 64'd2);
      // A start during SEARCH with a different target must be ignored.
      target = 16'h0061;
      start  = 1'b1;
      tick(1);                                   // after edge 5
      start  = 1'b0;
      tick(2);                                   // after edge 7
      check("t1_cand7_pw",  {48'd0, password}, 64'h6261);
      check("t1_e7_found",  {63'd0, found}, 64'd0);
      tick(1);                                   // after edge 8
      check("t1_done",  {63'd0, done},  64'd1);
      check("t1_found", {63'd0, found}, 64'd1);
      check("t1_busy",  {63'd0, busy},  64'd0);
      check("t1_att",   attempts, exp_att(7));
      check("t1_pw",    {48'd0, password}, 64'h6261);
      check("t1_len",   {56'd0, wordLength}, 64'd2);
      tick(3);
      check("t1_hold_found", {63'd0, found}, 64'd1);
      check("t1_hold_att",   attempts, exp_att(7));

      // Target "ab", offset 0, inc 2: 8 candidates, no match
      launch(16'h6162, 3'd0, 3'd2);
      tick(8);                                   // after edge 8
      check("t2_e8_busy", {63'd0, busy}, 64'd1);
      check("t2_e8_done", {63'd0, done}, 64'd0);
      tick(1);                                   // after edge 9
      check("t2_done",  {63'd0, done},  64'd1);
      check("t2_found", {63'd0, found}, 64'd0);
      check("t2_att",   attempts, exp_att(8));
      check("t2_pw",    {48'd0, password}, 64'h6363);

      // Target "ab", offset 1, inc 2: b, ab
      launch(16'h6162, 3'd1, 3'd2);
      tick(1);
      check("t3_cand1_pw", {48'd0, password}, 64'h0062);
      tick(2);                                   // after edge 3
      check("t3_found", {63'd0, found}, 64'd1);
      check("t3_att",   attempts, exp_att(2));
      check("t3_len",   {56'd0, wordLength}, 64'd2);
      check("t3_pw",    {48'd0, password}, 64'h6162);

      // Target "zz", inc 0 behaves as 1: 12 candidates ending at "cc"
      launch(16'h7a7a, 3'd0, 3'd0);
      tick(12);
      check("t4_e12_done", {63'd0, done}, 64'd0);
      tick(1);                                   // after edge 13
      check("t4_done",  {63'd0, done},  64'd1);
      check("t4_found", {63'd0, found}, 64'd0);
      check("t4_att",   attempts, exp_att(12));
      check("t4_pw",    {48'd0, password}, 64'h6363);
      check("t4_len",   {56'd0, wordLength}, 64'd2);

      // Abort at cycle 3
      launch(16'h6261, 3'd0, 3'd1);
      tick(2);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check_cleared("abort");
      tick(2);
      check("abort_idle_busy", {63'd0, busy}, 64'd0);

      // Reset at cycle 3
      launch(16'h6261, 3'd0, 3'd1);
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_cleared("reset");

      // Invalid start: offset >= stride
      launch(16'h6261, 3'd3, 3'd2);
      tick(1);
      check("inv1_done",  {63'd0, done},  64'd1);
      check("inv1_found", {63'd0, found}, 64'd0);
      check("inv1_busy",  {63'd0, busy},  64'd0);
      check("inv1_att",   attempts, 64'd0);

      // Invalid start: CHAR_MIN+offset beyond CHAR_MAX
      launch(16'h6261, 3'd3, 3'd4);
      tick(1);
      check("inv2_done",  {63'd0, done},  64'd1);
      check("inv2_found", {63'd0, found}, 64'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/brute_force_engine.md
# brute_force_engine

Parametrised successor to the fixed 16-character brute-force cracker. It generates candidate passwords of increasing length, from 1 to MAX_LEN characters, over a configurable character range. Each candidate is compared against a loaded target every cycle, and the engine stops on a match or when the space is exhausted. Several instances run in parallel, each taking an interleaved slice of the search space through `startingPosition` and `increment`.

## Interface
- `MAX_LEN`, default 16: maximum candidate length in characters.
- `CHAR_MIN`, default 8'h61: lowest character ('a').
- `CHAR_MAX`, default 8'h7A: highest character ('z').
- `clock` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: one-cycle pulse; captures the inputs below and begins the search.
- `abort` input 1: returns the engine to IDLE from any state.
- `target` input 8*MAX_LEN: target password.
  - Byte 0 is the first character.
  - Unused upper bytes must be 8'h00.
- `startingPosition` input 3: byte-0 offset from CHAR_MIN for this instance.
- `increment` input 3: byte-0 stride (instance count); 0 is treated as 1.
- `busy` output 1: high in SEARCH.
- `done` output 1: search finished, either found or exhausted.
- `found` output 1: match found; valid while `done`=1.
- `wordLength` output 8: length of the current or held candidate.
- `password` output 8*MAX_LEN: current or held candidate; unused bytes are 8'h00.
- `attempts` output 64: number of candidates compared.

## Operation
- States:
  - IDLE: waiting for `start`.
  - SEARCH: generating and comparing one candidate per cycle.
  - FOUND: match held.
  - EXHAUSTED: search space exhausted without a match.
- Reset (and `abort`):
  - State goes to IDLE.
  - `busy`, `done`, `found`, `attempts` = 0.
  - `wordLength` = 0.
  - `password` = all zeros.
- Start validation: `start` is accepted in IDLE, FOUND or EXHAUSTED. The effective increment is inc = (`increment`==0 ? 1 : `increment`).
  - If `startingPosition` >= inc, or CHAR_MIN+`startingPosition` > CHAR_MAX, the start is invalid. Next state is EXHAUSTED with `attempts`=0.
  - Otherwise the first candidate is loaded: `wordLength`=1, byte0 = CHAR_MIN+`startingPosition`, all other bytes 0. The state goes to SEARCH.
  - `target`, the offset and inc are registered at start. Later changes to these inputs are ignored until the next start.
- SEARCH compares the full `password` vector against the registered target every cycle.
  - On a match: go to FOUND. `password` and `wordLength` hold the match.
  - On no match: `attempts` increments by 1 and the candidate advances.
- Candidate advance (odometer over positions 0..`wordLength`-1):
  - Byte 0 += inc. If the result is greater than CHAR_MAX, byte 0 reloads CHAR_MIN+offset and carries into byte 1.
  - Bytes 1 and up increment by 1 on carry. On exceeding CHAR_MAX they wrap to CHAR_MIN and carry onward.
  - Carry out of position `wordLength`-1:
    - If `wordLength` < MAX_LEN: `wordLength`+1, byte0 = CHAR_MIN+offset, bytes 1..`wordLength` (new) = CHAR_MIN.
    - Otherwise: go to EXHAUSTED; `password` holds the last candidate.
- In FOUND, `attempts` also counts the matching candidate, so it equals the 1-based candidate index.
- Byte arithmetic uses 9 bits so that stride overflow past 8'hFF is detected as a carry.
- `abort` takes priority over `start`. `start` while in SEARCH is ignored.

## Timing
- The start pulse is sampled at edge 0. Candidate k (1-based) is registered after edge k.
- A match on candidate k gives `done`=`found`=1 after edge k+1, with `attempts`=k.
- Exhaustion after N candidates gives `done`=1, `found`=0 after edge N+1, with `attempts`=N.
- `done` and `found` hold until the next accepted `start`, `abort` or `reset`.
- The next accepted `start` clears `done` and `found` at the same edge it loads the first candidate.

## Configuration
- `BRUTE_FORCE_ATTEMPT_COUNT_EN` defined: the 64-bit `attempts` counter is implemented as specified above.
- `BRUTE_FORCE_ATTEMPT_COUNT_EN` undefined: no counter register is built and `attempts` is tied to 0. All other behaviour is unchanged.

## Test plan
The bench uses MAX_LEN=2, CHAR_MIN='a', CHAR_MAX='c', with the macro defined.

- Target "ba", offset 0, `increment` 1:
  - Sequence is a,b,c,aa,ab,ac,ba.
  - Required: `found`=1 after edge 8, `attempts`=7, `password`="ba", `wordLength`=2.
- Target "ab", offset 0, `increment` 2:
  - Sequence is a,c,aa,ac,ba,bc,ca,cc.
  - Required: `done`=1, `found`=0 after edge 9, `attempts`=8.
- Target "ab", offset 1, `increment` 2:
  - Sequence is b,ab.
  - Required: `found`=1, `attempts`=2, `wordLength`=2.
- Target "zz", `increment` 0 (treated as 1):
  - Required: 12 candidates, ending at "cc"; `done`=1, `found`=0, `attempts`=12.
- Mid-search and invalid-start cases:
  - `abort` at cycle 3: required all outputs 0 and state IDLE the next cycle.
  - Reset at cycle 3: same result as `abort`.
  - Start with `startingPosition` 3 and `increment` 2: required `done`=1, `found`=0, `attempts`=0 after edge 1.
